// File: rtl/cram_writer.sv
// Palette CRAM write port: merges Z80 byte-pair writes, DMA word writes and a range-fill engine
// into one registered CRAM write stream with fixed priority CPU > DMA > fill.
module cram_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic        cpu_a0,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        dma_req,
    input  logic [7:0]  dma_addr,
    input  logic [15:0] dma_data,
    output logic        dma_ack,
    input  logic        fill_start,
    input  logic [7:0]  fill_base,
    input  logic [7:0]  fill_len,
    input  logic [15:0] fill_data,
    output logic        fill_busy,
    output logic [7:0]  cram_addr_out,
    output logic [15:0] cram_data_out,
    output logic        cram_we
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StFill = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] fdata_q, fdata_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;

    logic cpu_commit, dma_grant, fill_grant;

    always_comb begin
        cpu_commit = cpu_wr & cpu_a0;
        // The ack of the previous DMA write blocks the next, spacing DMA writes two cycles apart.
        dma_grant  = ~cpu_commit & dma_req & ~ack_q;
        fill_grant = ~cpu_commit & ~dma_grant & (state_q == StFill);

        state_d = state_q;
        lo_d    = lo_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        fdata_d = fdata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ack_d   = dma_grant;

        if (cpu_wr && !cpu_a0) begin
            lo_d = cpu_data;
        end

        if (cpu_commit) begin
            addr_d = cpu_addr;
            data_d = {cpu_data, lo_q};
            we_d   = 1'b1;
        end else if (dma_grant) begin
            addr_d = dma_addr;
            data_d = dma_data;
            we_d   = 1'b1;
        end else if (fill_grant) begin
            addr_d = ptr_q;
            data_d = fdata_q;
            we_d   = 1'b1;
            ptr_d  = ptr_q + 8'd1;
            cnt_d  = cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
                state_d = StIdle;
            end
        end

        if (state_q == StIdle && fill_start) begin
            ptr_d   = fill_base;
            fdata_d = fill_data;
            cnt_d   = (fill_len == 8'd0) ? 9'd256 : {1'b0, fill_len};
            state_d = StFill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lo_q    <= 8'h00;
            ptr_q   <= 8'h00;
            cnt_q   <= 9'd0;
            fdata_q <= 16'h0000;
            addr_q  <= 8'h00;
            data_q  <= 16'h0000;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            fdata_q <= fdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
        end
    end

    assign cram_we       = we_q;
    assign cram_addr_out = addr_q;
    assign cram_data_out = data_q;
    assign dma_ack       = ack_q;
    assign fill_busy     = (state_q == StFill);

endmodule

// File: tb/tb_cram_writer.sv
// Scoreboard bench for cram_writer: stimulus pushes expected CRAM writes, a negedge monitor
// pops and checks each write's address, data, dma_ack and spacing from the previous write.
module tb_cram_writer;

    logic        clk;
    logic        rst;
    logic        cpu_wr, cpu_a0;
    logic [7:0]  cpu_addr, cpu_data;
    logic        dma_req;
    logic [7:0]  dma_addr;
    logic [15:0] dma_data;
    logic        dma_ack;
    logic        fill_start;
    logic [7:0]  fill_base, fill_len;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic [7:0]  cram_addr_out;
    logic [15:0] cram_data_out;
    logic        cram_we;

    cram_writer dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_wr        (cpu_wr),
        .cpu_a0        (cpu_a0),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .dma_req       (dma_req),
        .dma_addr      (dma_addr),
        .dma_data      (dma_data),
        .dma_ack       (dma_ack),
        .fill_start    (fill_start),
        .fill_base     (fill_base),
        .fill_len      (fill_len),
        .fill_data     (fill_data),
        .fill_busy     (fill_busy),
        .cram_addr_out (cram_addr_out),
        .cram_data_out (cram_data_out),
        .cram_we       (cram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        logic        ack;
        int          gap;   // required cycles since previous write, 0 = don't care
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   cyc      = 0;
    int   last_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] d, input logic ack, input int gap);
        exp_t e;
        e.a = a; e.d = d; e.ack = ack; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!dma_ack && n < 10);
        check(name, {31'd0, dma_ack}, 32'd1);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (fill_busy && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'd0, fill_busy}, 32'd0);
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (cram_we === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             cram_addr_out, cram_data_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("write_addr", {24'd0, cram_addr_out}, {24'd0, e.a});
                    check("write_data", {16'd0, cram_data_out}, {16'd0, e.d});
                    check("write_ack", {31'd0, dma_ack}, {31'd0, e.ack});
                    if (e.gap != 0) check("write_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
            end else begin
                check("idle_ack", {31'd0, dma_ack}, 32'd0);
            end
        end
    end

    initial begin
        int busy_cnt;
        rst = 1'b1;
        cpu_wr = 0; cpu_a0 = 0; cpu_addr = 0; cpu_data = 0;
        dma_req = 0; dma_addr = 0; dma_data = 0;
        fill_start = 0; fill_base = 0; fill_len = 0; fill_data = 0;
        tick(); tick();
        check("rst_we", {31'd0, cram_we}, 32'd0);
        check("rst_ack", {31'd0, dma_ack}, 32'd0);
        check("rst_busy", {31'd0, fill_busy}, 32'd0);
        check("rst_addr", {24'd0, cram_addr_out}, 32'd0);
        check("rst_data", {16'd0, cram_data_out}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // CPU low byte then commit, then a second commit reusing the latched low byte
        cpu_wr = 1; cpu_a0 = 0; cpu_data = 8'h34;
        tick();
        cpu_a0 = 1; cpu_addr = 8'h10; cpu_data = 8'h12;
        push(8'h10, 16'h1234, 1'b0, 0);
        check("lo_no_write", {31'd0, cram_we}, 32'd0);
        tick();
        cpu_wr = 0;
        tick(); tick();
        cpu_wr = 1; cpu_a0 = 1; cpu_addr = 8'h11; cpu_data = 8'hAB;
        push(8'h11, 16'hAB34, 1'b0, 0);
        tick();
        cpu_wr = 0;
        tick(); tick();

        // Fill wrapping past 0xFF
        fill_start = 1; fill_base = 8'hFE; fill_len = 8'd3; fill_data = 16'h7FFF;
        push(8'hFE, 16'h7FFF, 1'b0, 0);
        push(8'hFF, 16'h7FFF, 1'b0, 1);
        push(8'h00, 16'h7FFF, 1'b0, 1);
        tick();
        fill_start = 0;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (fill_busy) busy_cnt++;
            tick();
        end
        check("wrap_busy_cycles", busy_cnt, 3);

        // Full 256-entry fill
        fill_start = 1; fill_base = 8'h40; fill_len = 8'd0; fill_data = 16'h1357;
        for (int i = 0; i < 256; i++) push(8'(8'h40 + i), 16'h1357, 1'b0, (i == 0) ? 0 : 1);
        tick();
        fill_start = 0;
        wait_idle("fill256_done", 300);
        tick(); tick();

        // CPU commit, DMA request and active fill collide
        fill_start = 1; fill_base = 8'h80; fill_len = 8'd4; fill_data = 16'h5555;
        push(8'h80, 16'h5555, 1'b0, 0);
        push(8'h05, 16'hC034, 1'b0, 1);
        push(8'h06, 16'hBEEF, 1'b1, 1);
        push(8'h81, 16'h5555, 1'b0, 1);
        push(8'h82, 16'h5555, 1'b0, 1);
        push(8'h83, 16'h5555, 1'b0, 1);
        tick();
        fill_start = 0;
        tick();
        cpu_wr = 1; cpu_a0 = 1; cpu_addr = 8'h05; cpu_data = 8'hC0;
        dma_req = 1; dma_addr = 8'h06; dma_data = 16'hBEEF;
        tick();
        cpu_wr = 0;
        check("arb_no_early_ack", {31'd0, dma_ack}, 32'd0);
        wait_ack("arb_dma_ack");
        dma_req = 0;
        wait_idle("arb_fill_done", 20);
        tick(); tick();

        // DMA held high for three back-to-back words
        dma_req = 1; dma_addr = 8'hA0; dma_data = 16'h0A0A;
        push(8'hA0, 16'h0A0A, 1'b1, 0);
        push(8'hA1, 16'h0B0B, 1'b1, 2);
        push(8'hA2, 16'h0C0C, 1'b1, 2);
        wait_ack("dma_ack0");
        dma_addr = 8'hA1; dma_data = 16'h0B0B;
        wait_ack("dma_ack1");
        dma_addr = 8'hA2; dma_data = 16'h0C0C;
        wait_ack("dma_ack2");
        dma_req = 0;
        tick(); tick();

        // Reset two writes into a 10-entry fill; inputs during reset are ignored
        fill_start = 1; fill_base = 8'h20; fill_len = 8'd10; fill_data = 16'h0F0F;
        push(8'h20, 16'h0F0F, 1'b0, 0);
        push(8'h21, 16'h0F0F, 1'b0, 1);
        tick();
        fill_start = 0;
        tick(); tick();
        rst = 1;
        cpu_wr = 1; cpu_a0 = 0; cpu_data = 8'hEE;
        tick();
        rst = 0; cpu_wr = 0;
        check("rstfill_we", {31'd0, cram_we}, 32'd0);
        check("rstfill_busy", {31'd0, fill_busy}, 32'd0);
        check("rstfill_addr", {24'd0, cram_addr_out}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        fill_start = 1; fill_base = 8'h00; fill_len = 8'd1; fill_data = 16'h0001;
        push(8'h00, 16'h0001, 1'b0, 0);
        tick();
        fill_start = 0;
        check("refill_busy", {31'd0, fill_busy}, 32'd1);
        wait_idle("refill_done", 10);
        tick();
        // Low latch was cleared by reset and the write during reset was dropped
        cpu_wr = 1; cpu_a0 = 1; cpu_addr = 8'h30; cpu_data = 8'h77;
        push(8'h30, 16'h7700, 1'b0, 0);
        tick();
        cpu_wr = 0;
        for (int i = 0; i < 4; i++) tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000, expected completion");
        $fatal(1, "timeout");
    end

endmodule
